// File: rtl/adder_32b_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package adder_32b_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int CLA_GRP_W   = 4;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_32b_cla.sv
// 4-bit carry-lookahead group: local sum bits plus group propagate/generate
// for the second-level lookahead in the top.
module cla_4b
  import adder_32b_pkg::*;
(
  input  logic [CLA_GRP_W-1:0] a,
  input  logic [CLA_GRP_W-1:0] b,
  input  logic                 c_in,
  output logic [CLA_GRP_W-1:0] s,
  output logic                 p_grp,
  output logic                 g_grp
);

  logic [CLA_GRP_W-1:0] p;
  logic [CLA_GRP_W-1:0] g;
  logic [CLA_GRP_W-1:0] c;

  // Bit-level propagate/generate, in-group carries in flattened lookahead form.
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    s     = p ^ c;
    p_grp = &p;
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/adder_32b.sv
// Carry-lookahead adder with combinational result and an optional
// one-cycle registered copy qualified by out_valid.
module adder_32b
  import adder_32b_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  localparam int NG = WIDTH / CLA_GRP_W;

  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG:0]   grp_c;

  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             ovf_p1;
  logic             vld_p1;

  // Carry into group k as a sum of products over all lower groups, so every
  // group carry is a two-level function of P/G rather than a ripple.
  function automatic logic group_carry(input int k, input logic [NG-1:0] p,
                                       input logic [NG-1:0] g, input logic ci);
    logic acc;
    logic term;
    acc = ci;
    for (int m = 0; m < k; m++) acc = acc & p[m];
    for (int j = 0; j < k; j++) begin
      term = g[j];
      for (int m = j + 1; m < k; m++) term = term & p[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_cla
      cla_4b u_cla (
        .a    (in0[gi*CLA_GRP_W +: CLA_GRP_W]),
        .b    (in1[gi*CLA_GRP_W +: CLA_GRP_W]),
        .c_in (grp_c[gi]),
        .s    (sum[gi*CLA_GRP_W +: CLA_GRP_W]),
        .p_grp(grp_p[gi]),
        .g_grp(grp_g[gi])
      );
    end
  endgenerate

  // Second-level lookahead: group carries, carry out and overflow flag.
  always_comb begin
    for (int k = 0; k <= NG; k++) grp_c[k] = group_carry(k, grp_p, grp_g, cin);
    cout = grp_c[NG];
    ovf  = add_ovf(in0[WIDTH-1], in1[WIDTH-1], sum[WIDTH-1]);
  end

  // Stage p0 -> p1: capture the combinational result when in_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum;
        cout_p1 <= cout;
        ovf_p1  <= ovf;
      end
    end
  end

  assign sum_q     = sum_p1;
  assign cout_q    = cout_p1;
  assign ovf_q     = ovf_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_adder_32b.sv
// Randomized self-checking bench for adder_32b against an arithmetic model.
module tb_adder_32b;

  logic        clk;
  logic        rst_n;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        cin;
  logic        in_valid;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected registered state.
  logic [31:0] exp_sum_q;
  logic        exp_cout_q;
  logic        exp_ovf_q;
  logic        exp_vld;

  adder_32b #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0      (in0),
    .in1      (in1),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .sum_q    (sum_q),
    .cout_q   (cout_q),
    .ovf_q    (ovf_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from unsigned and signed integer arithmetic.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] u;
    longint      s;
    logic        v;
    u = {1'b0, a} + {1'b0, b} + {32'd0, c};
    s = longint'($signed(a)) + longint'($signed(b)) + (c ? 64'sd1 : 64'sd0);
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {v, u};
  endfunction

  task automatic check_comb(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [33:0] r;
    in0 = a; in1 = b; cin = c;
    #1;
    r = ref_add(a, b, c);
    check({tag, ".sum"},  64'(sum),  64'(r[31:0]));
    check({tag, ".cout"}, 64'(cout), 64'(r[32]));
    check({tag, ".ovf"},  64'(ovf),  64'(r[33]));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".vld"},    64'(out_valid), 64'(exp_vld));
    check({tag, ".sum_q"},  64'(sum_q),     64'(exp_sum_q));
    check({tag, ".cout_q"}, 64'(cout_q),    64'(exp_cout_q));
    check({tag, ".ovf_q"},  64'(ovf_q),     64'(exp_ovf_q));
  endtask

  // One clocked cycle: drive at negedge, update model, check after posedge.
  task automatic reg_cycle(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic v);
    logic [33:0] r;
    @(negedge clk);
    in0 = a; in1 = b; cin = c; in_valid = v;
    r = ref_add(a, b, c);
    @(posedge clk);
    #1;
    if (v) begin
      exp_sum_q  = r[31:0];
      exp_cout_q = r[32];
      exp_ovf_q  = r[33];
    end
    exp_vld = v;
    check_regs(tag);
  endtask

  initial begin
    logic [33:0] r;
    rst_n = 1'b1; in0 = '0; in1 = '0; cin = 1'b0; in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    exp_sum_q = '0; exp_cout_q = 1'b0; exp_ovf_q = 1'b0; exp_vld = 1'b0;
    check_regs("reset");

    // Directed combinational vectors, applied while reset is held.
    check_comb("zero",    32'h0000_0000, 32'h0000_0000, 1'b0);
    check_comb("3p1",     32'h0000_0003, 32'h0000_0001, 1'b0);
    check_comb("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check_comb("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check_comb("negovf",  32'h8000_0000, 32'h8000_0000, 1'b0);
    check_comb("cin",     32'h1234_5678, 32'h1111_1111, 1'b1);
    check_comb("allone",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_comb("cinwrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check("spot.cin", 64'(sum), 64'(32'h0000_0000));
    in0 = 32'h1234_5678; in1 = 32'h1111_1111; cin = 1'b1; #1;
    check("spot.2345678A", 64'(sum), 64'(32'h2345_678A));
    check_regs("reset_hold");

    // Random combinational vectors, biased toward carry-chain corners.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = ~a;
      if (i % 7 == 0) a = 32'hFFFF_FFFF;
      check_comb("rnd", a, b, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Registered path: three back-to-back captures then an idle cycle.
    reg_cycle("b2b0", 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b1);
    reg_cycle("b2b1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    reg_cycle("b2b2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    reg_cycle("idle", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    reg_cycle("idle2", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++)
      reg_cycle("rreg", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

    // Asynchronous reset between edges while a result is held.
    reg_cycle("pre_rst", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b1);
    check("pre_rst.vld_set", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_sum_q = '0; exp_cout_q = 1'b0; exp_ovf_q = 1'b0; exp_vld = 1'b0;
    check_regs("async_rst");
    r = ref_add(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
    check("async_rst.comb_sum",  64'(sum),  64'(r[31:0]));
    check("async_rst.comb_cout", 64'(cout), 64'(r[32]));
    @(posedge clk);
    #1;
    check_regs("rst_held");

    // Release between edges; the next valid edge captures again.
    @(negedge clk);
    rst_n = 1'b1;
    reg_cycle("resume", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    reg_cycle("resume2", 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b1);
    reg_cycle("resume_idle", 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_32b.md
ADDER_32B -- requirements
Module: adder_32b

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a multiple of 4 and is only verified at 32.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for the registered result path only.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in0  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 in1  input  WIDTH  operand B, unsigned or two's complement.
REQ-007 cin  input  1  carry-in; tie 0 for a plain add.
REQ-008 in_valid  input  1  request to capture the current result into the output registers.
REQ-009 sum  output  WIDTH  combinational in0+in1+cin, low WIDTH bits.
REQ-010 cout  output  1  combinational carry out of the MSB.
REQ-011 ovf  output  1  combinational signed overflow.
REQ-012 sum_q  output  WIDTH  registered sum.
REQ-013 cout_q  output  1  registered cout.
REQ-014 ovf_q  output  1  registered ovf.
REQ-015 out_valid  output  1  sum_q/cout_q/ovf_q hold a freshly captured result.

Function
REQ-016 sum SHALL equal (in0 + in1 + cin) mod 2^WIDTH, with zero clock latency, settling in the same evaluation step as the inputs, with no clock edge needed.
REQ-017 cout SHALL equal bit WIDTH of the (WIDTH+1)-bit unsigned sum.
REQ-018 ovf SHALL be 1 iff in0[MSB]==in1[MSB] and sum[MSB]!=in0[MSB].
REQ-019 The carry chain SHALL be carry-lookahead: 4-bit groups generate group P/G, and a second-level lookahead computes the group carries. A ripple-only chain is not allowed.
REQ-020 On each rising clk edge with in_valid=1, sum_q/cout_q/ovf_q SHALL load sum/cout/ovf and out_valid SHALL be set to 1.
REQ-021 On a rising edge with in_valid=0, out_valid SHALL become 0 and sum_q/cout_q/ovf_q SHALL hold their values.
REQ-022 Latency from in_valid to out_valid SHALL be exactly 1 cycle. There is no backpressure; back-to-back valid cycles SHALL produce back-to-back results.
REQ-023 Wrap-around: all-ones + 1 SHALL give sum=0 and cout=1, with no error indication beyond cout/ovf.
REQ-024 X/undriven inputs are out of scope; outputs SHALL have no latches and no combinational loops.

Reset
REQ-025 While rst_n=0, sum_q, cout_q, ovf_q and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-026 Reset SHALL NOT affect the combinational outputs sum/cout/ovf.
REQ-027 Deassertion of rst_n mid-stream SHALL resume capture on the first rising edge with rst_n=1 and in_valid=1.
REQ-028 Assertion of rst_n mid-stream SHALL discard any pending result.

Structure
REQ-029 A shared package SHALL hold the WIDTH default constant (32) and the CLA group size constant (4).
REQ-030 A single sub-module, cla_4b, SHALL be used: inputs a[3:0], b[3:0] and c_in; outputs s[3:0], group propagate and group generate. It SHALL be instantiated WIDTH/4 times.
REQ-031 The top level SHALL contain the second-level lookahead carry logic, the flag logic and the output registers.

Verification
REQ-032 in0=0, in1=0, cin=0 -> sum=0, cout=0, ovf=0, all in the same step with no clock.
REQ-033 in0=3, in1=1, cin=0 -> sum=4, cout=0, ovf=0.
REQ-034 in0=0xFFFFFFFF, in1=1 -> sum=0x00000000, cout=1, ovf=0; and in0=0x7FFFFFFF, in1=1 -> sum=0x80000000, cout=0, ovf=1.
REQ-035 in0=0x80000000, in1=0x80000000 -> sum=0, cout=1, ovf=1; and in0=0x12345678, in1=0x11111111, cin=1 -> sum=0x2345678A.
REQ-036 Registered path: in_valid=1 for 3 consecutive cycles with distinct operands -> out_valid=1 on cycles +1..+3 with matching sum_q values; in_valid=0 -> out_valid=0 next edge while sum_q holds its value.
REQ-037 Reset: pull rst_n low between clock edges while out_valid=1 -> sum_q=0 and out_valid=0 immediately, while the combinational sum is still correct.
